// File: rtl/sw_pkg.sv
// sw_pkg: shared switch count and default debounce interval for top and bench
package sw_pkg;

    localparam int NUM_SW            = 8;
    localparam int DEF_STABLE_CYCLES = 1_000_000;

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: 2-flop synchronizer, stability counter, clean level and edge pulses for one switch
module debounce_bit
    import sw_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic fire
);

    localparam int            CW   = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);

    logic          sync0;
    logic          sync1;
    logic [CW-1:0] cnt;

    assign fire = (sync1 != clean) && (cnt == CMAX);

    // synchronize, count consecutive mismatch cycles, accept the new level on the last one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            cnt   <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync0 <= sw_raw;
            sync1 <= sync0;
            cnt   <= (sync1 == clean || fire) ? '0 : cnt + 1'b1;
            clean <= fire ? sync1 : clean;
            rise  <= fire & sync1;
            fall  <= fire & ~sync1;
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: independent per-bit debouncing of board switches with edge pulses
module switch_debouncer
    import sw_pkg::*;
#(
    parameter int WIDTH         = NUM_SW,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             any_change
);

    logic [WIDTH-1:0] fire;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .sw_raw(sw_raw[i]),
            .clean (sw_clean[i]),
            .rise  (sw_rise[i]),
            .fall  (sw_fall[i]),
            .fire  (fire[i])
        );
    end

    // registered from the same fire terms that load the rise/fall flops, so it aligns with them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) any_change <= 1'b0;
        else        any_change <= |fire;
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed checks of debounce latency, glitch rejection and reset behaviour
module tb_switch_debouncer;
    import sw_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NUM_SW-1:0] sw_raw = '0;
    logic [NUM_SW-1:0] sw_clean;
    logic [NUM_SW-1:0] sw_rise;
    logic [NUM_SW-1:0] sw_fall;
    logic              any_change;

    int checks = 0;
    int passed = 0;

    switch_debouncer #(
        .WIDTH(NUM_SW),
        .STABLE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_raw    (sw_raw),
        .sw_clean  (sw_clean),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .any_change(any_change)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] pack(input logic [7:0] c, input logic [7:0] r,
                                         input logic [7:0] f, input logic a);
        return {7'b0, c, r, f, a};
    endfunction

    function automatic logic [31:0] outs();
        return pack(sw_clean, sw_rise, sw_fall, any_change);
    endfunction

    // drive nv, expect old level for 5 edges, change with pulses on the 6th, quiet on the 7th
    task automatic step(input string tag, input logic [7:0] ov, input logic [7:0] nv,
                        input logic [7:0] r, input logic [7:0] f);
        sw_raw = nv;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk({tag, "_hold"}, outs(), pack(ov, 8'h00, 8'h00, 1'b0));
        end
        tick();
        chk({tag, "_edge"}, outs(), pack(nv, r, f, 1'b1));
        tick();
        chk({tag, "_after"}, outs(), pack(nv, 8'h00, 8'h00, 1'b0));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 chk("reset", outs(), 32'h0);
        tick();
        tick();
        chk("reset_hold", outs(), 32'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("idle", outs(), 32'h0);
        end
        step("b0_rise", 8'h00, 8'h01, 8'h01, 8'h00);
        step("b0_fall", 8'h01, 8'h00, 8'h00, 8'h01);
        for (int g = 0; g < 5; g++) begin
            sw_raw = 8'h01;
            for (int k = 0; k < 3; k++) begin
                tick();
                chk("glitch_hi", outs(), 32'h0);
            end
            sw_raw = 8'h00;
            for (int k = 0; k < 3; k++) begin
                tick();
                chk("glitch_lo", outs(), 32'h0);
            end
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("glitch_settle", outs(), 32'h0);
        end
        step("a5", 8'h00, 8'hA5, 8'hA5, 8'h00);
        step("ff", 8'hA5, 8'hFF, 8'h5A, 8'h00);
        sw_raw = 8'h00;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("abort_hold", outs(), pack(8'hFF, 8'h00, 8'h00, 1'b0));
        end
        rst_n = 1'b0;
        #1 chk("abort_async", outs(), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("abort_quiet", outs(), 32'h0);
        end
        rst_n = 1'b0;
        sw_raw = 8'h0C;
        tick();
        chk("rst_0c", outs(), 32'h0);
        rst_n = 1'b1;
        step("rel_0c", 8'h00, 8'h0C, 8'h0C, 8'h00);
        step("mixed", 8'h0C, 8'h03, 8'h03, 8'h0C);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
